// File: rtl/addsub_pkg.sv
// Shared types and helpers for the chunk-serial adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } addsub_state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  // Signed saturation limit for a dw-bit result (dw <= 64).
  // sign=0 -> 0x7FF..F, sign=1 -> 0x800..0; caller truncates to dw bits.
  function automatic logic [63:0] sat_value(input logic sign, input int dw);
    logic [63:0] v;
    v = 64'd1 << (dw - 1);
    if (!sign) begin
      v = v - 64'd1;
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// CW-bit ripple adder slice; also exposes the carry into its top bit for overflow detection.
// Latency: combinational.
// Backpressure: n/a.
module addsub_chunk
  import addsub_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          c_msb_in
);

  logic [CW:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_bit
    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_c[i]),
      .s   (sum[i]),
      .cout(w_c[i+1])
    );
  end

  assign cout     = w_c[CW];
  assign c_msb_in = w_c[CW-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell built from two half adders.
// Latency: combinational.
// Backpressure: n/a.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (.a(a),    .b(b),   .s(w_s1), .c(w_c1));
  half_adder u_ha1 (.a(w_s1), .b(cin), .s(s),    .c(w_c2));

  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder cell.
// Latency: combinational.
// Backpressure: n/a.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/addsub_seq.sv
// Chunk-serial DW-bit add/subtract, LSB chunk first, one CW-bit chunk per clock; optional saturation via ADDSUB_SAT_EN.
// Latency: start accepted at edge E0, busy for DW/CW cycles, done pulses in cycle DW/CW+1.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted back-to-back.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int DW = 32,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          add_sub,
  input  logic [DW-1:0] dataa,
  input  logic [DW-1:0] datab,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry_out,
  output logic          overflow
);

  localparam int NCHUNK = DW / CW;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  addsub_state_t r_state;
  addsub_state_t w_next;

  logic [DW-1:0]   r_a;
  logic [DW-1:0]   r_b;       // already inverted for subtract
  logic            r_carry;
  logic [CNTW-1:0] r_cnt;
  logic [DW-1:0]   r_result;
  logic            r_cout;
  logic            r_ovf;

  logic [CW-1:0]   w_sum;
  logic            w_cout;
  logic            w_cmsb;
  logic            w_last;
  logic            w_accept;
  logic            w_ovf;

  addsub_chunk #(.CW(CW)) u_chunk (
    .a       (r_a[r_cnt*CW +: CW]),
    .b       (r_b[r_cnt*CW +: CW]),
    .cin     (r_carry),
    .sum     (w_sum),
    .cout    (w_cout),
    .c_msb_in(w_cmsb)
  );

  assign w_last   = (r_cnt == CNTW'(NCHUNK - 1));
  // A new request is taken whenever no chunk work is in flight (IDLE or DONE).
  assign w_accept = start && (r_state != RUN);
  assign w_ovf    = w_cmsb ^ w_cout;

`ifdef ADDSUB_SAT_EN
  // Overflow implies both effective operand signs agree, so A's sign picks the limit.
  logic [DW-1:0] w_sat;
  assign w_sat = DW'(sat_value(r_a[DW-1], DW));
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, per-chunk result write, carry chain and flag update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= dataa;
      r_b     <= (add_sub == OP_ADD) ? datab : ~datab;
      r_carry <= (add_sub == OP_SUB);
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_result[r_cnt*CW +: CW] <= w_sum;
      r_carry                  <= w_cout;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= w_cout;
        r_ovf  <= w_ovf;
`ifdef ADDSUB_SAT_EN
        if (w_ovf) begin
          r_result <= w_sat;
        end
`endif
      end else begin
        r_cnt <= r_cnt + CNTW'(1);
      end
    end
  end

  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule
